mario_poll_unit: RTL

Collision-probe responder that produces the four 3-bit tile codes (`mario_poll_up/down/left/right`) consumed by the Mario movement block. On each frame_clk rising edge it latches Mario's centre position and computes four probe points just outside Mario's bounding box. It then reads the level tile map through a synchronous 1-cycle-latency read port and commits all four codes atomically. It sits between the Mario block and the level tile ROM/RAM.

---
 rtl/mario_poll_unit.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mario_poll_unit.sv
// Collision-probe responder: on each frame strobe, reads the four tile codes
// around Mario's bounding box and commits them atomically to the poll outputs.
module mario_poll_unit #(
  parameter logic [9:0] FIELD_X_MIN = 10'd120,
  parameter logic [9:0] FIELD_X_MAX = 10'd519,
  parameter logic [9:0] FIELD_Y_MIN = 10'd40,
  parameter logic [9:0] FIELD_Y_MAX = 10'd439,
  parameter logic [9:0] MARIO_SIZE  = 10'd20,
  parameter int         TILE_SHIFT  = 4,
  parameter int         MAP_COLS    = 25,
  parameter int         ADDR_W      = 10,
  parameter logic [2:0] OOB_CODE    = 3'b111
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_clk,
  input  logic [9:0]        Mario_X_Pos,
  input  logic [9:0]        Mario_Y_Pos,
  output logic [ADDR_W-1:0] tile_addr,
  output logic              tile_rd,
  input  logic [2:0]        tile_data,
  output logic [2:0]        mario_poll_up,
  output logic [2:0]        mario_poll_down,
  output logic [2:0]        mario_poll_left,
  output logic [2:0]        mario_poll_right,
  output logic              poll_busy,
  output logic              poll_valid
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    P_UP    = 3'd1,
    P_DOWN  = 3'd2,
    P_LEFT  = 3'd3,
    P_RIGHT = 3'd4,
    P_LAST  = 3'd5,
    COMMIT  = 3'd6
  } state_t;

  state_t state_reg, state_next;

  logic              fc_sync1_reg, fc_sync2_reg, rise_reg;
  logic [9:0]        x_reg, y_reg;
  logic [ADDR_W-1:0] addr_hold_reg;
  logic              rd_prev_reg;
  logic [2:0]        shadow_reg [4];

  logic              start, probe_active, cap_en, commit;
  logic [1:0]        probe_idx, cap_idx;

  logic [10:0]       x_ext, y_ext, s_ext;
  logic [10:0]       px_w [4];
  logic [10:0]       py_w [4];
  logic [3:0]        oob;
  logic [ADDR_W-1:0] probe_addr [4];

  assign x_ext = {1'b0, x_reg};
  assign y_ext = {1'b0, y_reg};
  assign s_ext = {1'b0, MARIO_SIZE};

  // Probe order: 0=up, 1=down, 2=left, 3=right. OOB is decided on the
  // unsubtracted coordinate, so the subtracted points below never matter when OOB.
  assign oob[0] = y_ext < ({1'b0, FIELD_Y_MIN} + s_ext + 11'd1);
  assign oob[1] = (y_ext + s_ext) > {1'b0, FIELD_Y_MAX};
  assign oob[2] = x_ext < ({1'b0, FIELD_X_MIN} + s_ext + 11'd1);
  assign oob[3] = (x_ext + s_ext) > {1'b0, FIELD_X_MAX};

  assign px_w[0] = x_ext;
  assign py_w[0] = y_ext - s_ext - 11'd1;
  assign px_w[1] = x_ext;
  assign py_w[1] = y_ext + s_ext;
  assign px_w[2] = x_ext - s_ext - 11'd1;
  assign py_w[2] = y_ext;
  assign px_w[3] = x_ext + s_ext;
  assign py_w[3] = y_ext;

  for (genvar gi = 0; gi < 4; gi++) begin : g_probe
    logic [10:0] dx, dy;
    assign dx = px_w[gi] - {1'b0, FIELD_X_MIN};
    assign dy = py_w[gi] - {1'b0, FIELD_Y_MIN};
    assign probe_addr[gi] = ADDR_W'(dy >> TILE_SHIFT) * ADDR_W'(MAP_COLS)
                          + ADDR_W'(dx >> TILE_SHIFT);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    start        = 1'b0;
    probe_active = 1'b0;
    probe_idx    = 2'd0;
    cap_en       = 1'b0;
    cap_idx      = 2'd0;
    commit       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rise_reg) begin
          start      = 1'b1;
          state_next = P_UP;
        end
      end
      P_UP: begin
        probe_active = 1'b1;
        probe_idx    = 2'd0;
        state_next   = P_DOWN;
      end
      P_DOWN: begin
        probe_active = 1'b1;
        probe_idx    = 2'd1;
        cap_en       = 1'b1;
        cap_idx      = 2'd0;
        state_next   = P_LEFT;
      end
      P_LEFT: begin
        probe_active = 1'b1;
        probe_idx    = 2'd2;
        cap_en       = 1'b1;
        cap_idx      = 2'd1;
        state_next   = P_RIGHT;
      end
      P_RIGHT: begin
        probe_active = 1'b1;
        probe_idx    = 2'd3;
        cap_en       = 1'b1;
        cap_idx      = 2'd2;
        state_next   = P_LAST;
      end
      P_LAST: begin
        cap_en     = 1'b1;
        cap_idx    = 2'd3;
        state_next = COMMIT;
      end
      COMMIT: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // An OOB probe issues no read and leaves the address bus where it was.
  assign tile_rd   = probe_active & ~oob[probe_idx];
  assign tile_addr = tile_rd ? probe_addr[probe_idx] : addr_hold_reg;
  assign poll_busy = (state_reg != IDLE);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      fc_sync1_reg     <= 1'b0;
      fc_sync2_reg     <= 1'b0;
      rise_reg         <= 1'b0;
      x_reg            <= '0;
      y_reg            <= '0;
      addr_hold_reg    <= '0;
      rd_prev_reg      <= 1'b0;
      for (int i = 0; i < 4; i++) shadow_reg[i] <= 3'b000;
      mario_poll_up    <= 3'b000;
      mario_poll_down  <= 3'b000;
      mario_poll_left  <= 3'b000;
      mario_poll_right <= 3'b000;
      poll_valid       <= 1'b0;
    end else begin
      fc_sync1_reg  <= frame_clk;
      fc_sync2_reg  <= fc_sync1_reg;
      rise_reg      <= fc_sync1_reg & ~fc_sync2_reg;
      addr_hold_reg <= tile_addr;
      rd_prev_reg   <= tile_rd;
      if (start) begin
        x_reg <= Mario_X_Pos;
        y_reg <= Mario_Y_Pos;
      end
      if (cap_en) shadow_reg[cap_idx] <= rd_prev_reg ? tile_data : OOB_CODE;
      poll_valid <= commit;
      if (commit) begin
        mario_poll_up    <= shadow_reg[0];
        mario_poll_down  <= shadow_reg[1];
        mario_poll_left  <= shadow_reg[2];
        mario_poll_right <= shadow_reg[3];
      end
    end
  end

endmodule
